// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result FIFO: depth default, entry layout,
// flag bit positions and the occupancy state encoding.
package alu_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int ENTRY_W   = 8;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Entry layout: {Y[3:0], C, V, N, Z} with Z at bit 0.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [3:0] y,
                                                    input logic c,
                                                    input logic v,
                                                    input logic n,
                                                    input logic z);
    logic [ENTRY_W-1:0] e;
    e         = {y, 4'b0000};
    e[FLAG_C] = c;
    e[FLAG_V] = v;
    e[FLAG_N] = n;
    e[FLAG_Z] = z;
    return e;
  endfunction

endpackage

// File: rtl/alu_res_mem.sv
// Result storage: DEPTH x ENTRY_W register array, one synchronous write port
// and one combinational read port. Contents are deliberately not reset.
module alu_res_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO of packed ALU results with sticky flag
// accumulation and a sticky drop indicator for results offered while full.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_y,
  input  logic                     in_c,
  input  logic                     in_v,
  input  logic                     in_n,
  input  logic                     in_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ENTRY_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               sticky_flags,
  input  logic                     clr_sticky,
  output logic                     drop_err,
  output occ_state_e               dbg_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a beat transfers on a port only in a cycle where both valid
  // and ready are high at the rising edge; ready never depends on the
  // opposite port's ready, and valid never depends on ready.

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         sticky_q, sticky_d;
  logic               drop_q, drop_d;
  occ_state_e         occ_q, occ_d;

  logic               push, pop, drop;
  logic               is_full, is_empty;
  logic [ENTRY_W-1:0] wr_entry, head;

  assign is_full   = (occ_q == OCC_FULL);
  assign is_empty  = (occ_q == OCC_EMPTY);
  assign in_ready  = ena & ~is_full;
  assign out_valid = ena & ~is_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;
  assign drop      = ena & in_valid & is_full;
  assign wr_entry  = pack_entry(in_y, in_c, in_v, in_n, in_z);

  alu_res_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    unique case (occ_q)
      OCC_EMPTY: if (push) occ_d = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (push && !pop && count_q == CW'(DEPTH - 1)) occ_d = OCC_FULL;
        else if (pop && !push && count_q == CW'(1))    occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_d = OCC_PARTIAL;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Clear is applied before this cycle's push/drop so new events survive it.
  always_comb begin
    sticky_d = clr_sticky ? 4'b0000 : sticky_q;
    drop_d   = clr_sticky ? 1'b0    : drop_q;
    if (push) begin
      sticky_d[FLAG_C] = sticky_d[FLAG_C] | in_c;
      sticky_d[FLAG_V] = sticky_d[FLAG_V] | in_v;
      sticky_d[FLAG_N] = sticky_d[FLAG_N] | in_n;
      sticky_d[FLAG_Z] = sticky_d[FLAG_Z] | in_z;
    end
    if (drop) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= OCC_EMPTY;
      sticky_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  assign out_data     = is_empty ? '0 : head;
  assign count        = count_q;
  assign sticky_flags = sticky_q;
  assign drop_err     = drop_q;
  assign dbg_occ      = occ_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed + short random bench for alu_result_fifo with a queue scoreboard
// and a small occupancy/sticky reference model.
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena, in_valid, in_ready;
  logic [3:0]       in_y;
  logic             in_c, in_v, in_n, in_z;
  logic             out_valid, out_ready;
  logic [7:0]       out_data;
  logic [2:0]       count;
  logic [3:0]       sticky_flags;
  logic             clr_sticky, drop_err;
  occ_state_e       dbg_occ;

  int               total = 0;
  int               bad   = 0;
  logic [7:0]       exp_q[$];
  int               m_cnt;
  logic [3:0]       m_sticky;
  logic             m_drop;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_c(in_c), .in_v(in_v), .in_n(in_n), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky),
    .drop_err(drop_err), .dbg_occ(dbg_occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; clr_sticky = 0;
    in_y = 0; in_c = 0; in_v = 0; in_n = 0; in_z = 0;
  endtask

  task automatic set_in(input logic [3:0] y, input logic c, input logic v,
                        input logic n, input logic z);
    in_valid = 1; in_y = y; in_c = c; in_v = v; in_n = n; in_z = z;
  endtask

  // Drives the currently set inputs for one clock, checking before and after.
  task automatic step();
    logic full, e_push, e_pop;
    logic [7:0] ent;
    #1;
    full   = (m_cnt == DEPTH);
    e_push = ena && in_valid && !full;
    e_pop  = ena && out_ready && (m_cnt != 0);
    check("in_ready", in_ready, ena && !full);
    check("out_valid", out_valid, ena && (m_cnt != 0));
    if (m_cnt == 0) check("out_data_empty", out_data, 0);
    if (e_pop) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
      else check("pop_data", out_data, exp_q.pop_front());
    end
    ent = {in_y, in_c, in_v, in_n, in_z};
    if (e_push) exp_q.push_back(ent);
    if (clr_sticky) begin m_sticky = 0; m_drop = 0; end
    if (e_push) m_sticky = m_sticky | {in_c, in_v, in_n, in_z};
    if (ena && in_valid && full) m_drop = 1;
    m_cnt = m_cnt + int'(e_push) - int'(e_pop);
    @(posedge clk); #1;
    check("count", count, m_cnt);
    check("sticky", sticky_flags, m_sticky);
    check("drop_err", drop_err, m_drop);
    idle();
  endtask

  initial begin
    rst_n = 0; ena = 1; idle();
    m_cnt = 0; m_sticky = 0; m_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_drop", drop_err, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Single push, latency 1 to head.
    set_in(4'd5, 0, 0, 0, 0); step();
    check("first_valid", out_valid, 1);
    check("first_data", out_data, 8'h50);
    check("first_count", count, 1);
    out_ready = 1; step();

    // Fill to full, offer one more, then drain in order.
    for (int i = 1; i <= 4; i++) begin set_in(4'(i), 0, 0, 0, 0); step(); end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    check("full_occ", dbg_occ, OCC_FULL);
    set_in(4'd9, 0, 0, 0, 0); step();
    check("drop_set", drop_err, 1);
    check("head_after_drop", out_data, 8'h10);
    // Pop while full with a new offer: pop happens, push refused, drop stays.
    set_in(4'd6, 0, 0, 0, 0); out_ready = 1; step();
    for (int i = 0; i < 3; i++) begin out_ready = 1; step(); end
    check("drained_count", count, 0);
    check("drained_valid", out_valid, 0);
    clr_sticky = 1; step();
    check("drop_cleared", drop_err, 0);

    // Steady push+pop at count 2 across pointer wrap.
    set_in(4'd6, 0, 0, 0, 0); step();
    set_in(4'd7, 0, 0, 0, 1); step();
    for (int i = 0; i < 10; i++) begin
      set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 0, 0);
      out_ready = 1; step();
      check("steady_count", count, 2);
    end
    for (int i = 0; i < 2; i++) begin out_ready = 1; step(); end

    // Sticky accumulation and clear-with-push ordering.
    clr_sticky = 1; step();
    set_in(4'd8, 0, 0, 1, 0); step();
    set_in(4'd0, 0, 0, 0, 1); step();
    check("sticky_nz", sticky_flags, 4'b0011);
    set_in(4'd3, 1, 0, 0, 0); clr_sticky = 1; step();
    check("sticky_clr_push", sticky_flags, 4'b1000);
    for (int i = 0; i < 3; i++) begin out_ready = 1; step(); end

    // Enable low holds everything; clear still applies.
    set_in(4'd1, 0, 0, 0, 0); step();
    set_in(4'd2, 0, 0, 0, 0); step();
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(4'd15, 1, 1, 1, 1); out_ready = 1; clr_sticky = (i == 2); step();
      check("dis_count", count, 2);
    end
    check("dis_sticky_clr", sticky_flags, 0);
    ena = 1;
    for (int i = 0; i < 2; i++) begin out_ready = 1; step(); end

    // Asynchronous reset mid-stream with count 3 and drop set.
    for (int i = 0; i < 4; i++) begin set_in(4'(10 + i), 0, 1, 0, 0); step(); end
    set_in(4'd0, 0, 0, 0, 0); step();
    out_ready = 1; step();
    check("pre_rst_count", count, 3);
    check("pre_rst_drop", drop_err, 1);
    #2 rst_n = 0;
    #1;
    check("async_count", count, 0);
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_drop", drop_err, 0);
    check("async_sticky", sticky_flags, 0);
    check("async_in_ready", in_ready, 1);
    exp_q.delete(); m_cnt = 0; m_sticky = 0; m_drop = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    set_in(4'd10, 0, 0, 0, 0); step();
    check("post_rst_head", out_data, 8'hA0);
    out_ready = 1; step();

    // Short random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1)
        set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready  = ($urandom_range(0, 2) == 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; power of two, 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  block enable; low = no push, no pop, state held.
REQ-005 in_valid  input  1  ALU result present on in_y/in_c/in_v/in_n/in_z.
REQ-006 in_ready  output  1  FIFO can accept a result this cycle.
REQ-007 in_y  input  4  ALU 4-bit result Y.
REQ-008 in_c, in_v, in_n, in_z  input  1 each  ALU carry, overflow, negative, zero flags.
REQ-009 out_valid  output  1  head entry is valid on out_data.
REQ-010 out_ready  input  1  consumer takes head entry this cycle.
REQ-011 out_data  output  8  head entry packed {Y[3:0], C, V, N, Z}, Z at bit 0.
REQ-012 count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-013 sticky_flags  output  4  {C,V,N,Z} OR of every accepted push since last clear.
REQ-014 clr_sticky  input  1  synchronous clear of sticky_flags and drop_err.
REQ-015 drop_err  output  1  sticky: a result was offered while full and lost.

Function
REQ-016 Push = ena & in_valid & in_ready; pop = ena & out_valid & out_ready.
REQ-017 in_ready SHALL be ena & (count < DEPTH); no combinational path from out_ready.
REQ-018 out_valid SHALL be ena & (count != 0); out_data SHALL show head entry combinationally from storage (first-word fall-through), zero when count==0.
REQ-019 Push writes packed entry at wr_ptr, wr_ptr increments mod DEPTH; pop increments rd_ptr mod DEPTH.
REQ-020 Occupancy states EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions only by push/pop, count +1 push-only, -1 pop-only, unchanged for both or neither.
REQ-021 Simultaneous push and pop in PARTIAL: both occur, count unchanged, written entry not visible at head same cycle.
REQ-022 In EMPTY, push makes entry visible at out_data the following cycle (latency 1); pop request ignored.
REQ-023 In FULL, in_ready=0 even if pop occurs this cycle; in_valid with ena high sets drop_err next cycle.
REQ-024 Push ORs {in_c,in_v,in_n,in_z} into sticky_flags next cycle.
REQ-025 clr_sticky with same-cycle push: clear applied first, then that push's flags ORed in; same-cycle drop: drop_err ends set.
REQ-026 ena low: pointers, count, storage, sticky_flags, drop_err held; clr_sticky still honoured.

Reset
REQ-027 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, count, sticky_flags, drop_err.
REQ-028 During and after reset: in_ready=ena, out_valid=0, out_data=0, count=0; storage contents need not be cleared.
REQ-029 Reset mid-operation discards all stored entries; first push after release lands at head.

Structure
REQ-030 Shared package alu_pkg SHALL hold DEPTH default, entry width 8, and flag bit indices (Z=0,N=1,V=2,C=3).
REQ-031 One sub-module alu_res_mem: DEPTH x 8 register array, one write port, one combinational read port, no reset.
REQ-032 Pointer, count, and sticky logic stay in alu_result_fifo.

Verification
REQ-033 Reset then push Y=5,C=0,V=0,N=0,Z=0 -> next cycle out_valid=1, out_data=0x50, count=1.
REQ-034 Push 4 results 0x1,0x2,0x3,0x4 (no pop) -> count=4, in_ready=0; 5th offer -> drop_err=1, pops return 0x10,0x20,0x30,0x40 in order.
REQ-035 Continuous push+pop for 10 cycles with count=2 -> count stays 2, order preserved across pointer wrap.
REQ-036 Push Y=8,N=1 then Y=0,Z=1 -> sticky_flags=4'b0011; clr_sticky with push of C=1 -> sticky_flags=4'b1000.
REQ-037 ena=0 with in_valid=1,out_ready=1 for 3 cycles -> in_ready=0, out_valid=0, count unchanged.
REQ-038 Assert rst_n=0 mid-stream with count=3 -> count=0, out_valid=0 immediately (asynchronous), drop_err=0.
